// File: rtl/mux_tdm_pkg.sv
// Shared types for the TDM scanning multiplexer: FSM state encoding and mode values.
package mux_tdm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    HOLD
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

endpackage

// File: rtl/rr_pick_next.sv
// Round-robin channel picker: first set mask bit at or above start (wrapping),
// plus a flag telling whether that bit is the highest set bit of the mask.
module rr_pick_next #(
  parameter  int N_CH  = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] index,
  output logic             is_last
);

  // Rotating a doubled mask lines bit 'start' up at position 0, so the
  // first set bit of the low half is the wrapped ascending search result.
  always_comb begin
    logic [2*N_CH-1:0] dbl;
    logic [N_CH-1:0]   rot;
    int                off;
    int                pos;
    int                hi;
    found   = 1'b0;
    index   = '0;
    is_last = 1'b0;
    off     = 0;
    hi      = 0;
    dbl     = {mask, mask} >> start;
    rot     = dbl[N_CH-1:0];
    for (int i = 0; i < N_CH; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = i;
      end
      if (mask[i]) begin
        hi = i;
      end
    end
    pos = int'(start) + off;
    if (pos >= N_CH) begin
      pos = pos - N_CH;
    end
    index   = SEL_W'(pos);
    is_last = found && (index == SEL_W'(hi));
  end

endmodule

// File: rtl/mux_tdm_scan.sv
// N-channel TDM multiplexer with manual select or round-robin auto-scan and a valid/ready output.
// Optional parity output is enabled by defining MUX_TDM_PARITY_EN.
module mux_tdm_scan
  import mux_tdm_pkg::*;
#(
  parameter  int N_CH   = 8,
  parameter  int DATA_W = 8,
  parameter  int DWELL  = 4,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel_in,
  input  logic [N_CH-1:0]        ch_mask,
  input  logic [N_CH*DATA_W-1:0] data_in,
  output logic [DATA_W-1:0]      data_out,
  output logic [SEL_W-1:0]       ch_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   scan_wrap
`ifdef MUX_TDM_PARITY_EN
  ,
  output logic                   data_par
`endif
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LOAD = DW_W'(DWELL - 1);

  state_t            state, state_nxt;
  logic [DW_W-1:0]   dwell_cnt, dwell_nxt;
  logic [SEL_W-1:0]  scan_ptr, ptr_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic [SEL_W-1:0]  ch_nxt;
  logic              valid_nxt, wrap_nxt;
  logic              hold_auto, auto_nxt;
  logic              hold_last, last_nxt;
  logic              pick_found, pick_last;
  logic [SEL_W-1:0]  pick_index;
  logic [SEL_W-1:0]  sample_ch;
  logic [DATA_W-1:0] sample_word;
`ifdef MUX_TDM_PARITY_EN
  logic              par_nxt;
`endif

  // Out-of-range indices match no channel and therefore yield zero.
  function automatic logic [DATA_W-1:0] chan_word(input logic [N_CH*DATA_W-1:0] bus,
                                                  input logic [SEL_W-1:0] idx);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (idx == SEL_W'(k)) begin
        w = bus[k*DATA_W +: DATA_W];
      end
    end
    return w;
  endfunction

  rr_pick_next #(.N_CH(N_CH)) u_pick (
    .mask    (ch_mask),
    .start   (scan_ptr),
    .found   (pick_found),
    .index   (pick_index),
    .is_last (pick_last)
  );

  assign sample_ch   = (mode == MODE_AUTO) ? pick_index : sel_in;
  assign sample_word = chan_word(data_in, sample_ch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dwell_cnt <= '0;
      scan_ptr  <= '0;
      data_out  <= '0;
      ch_out    <= '0;
      out_valid <= 1'b0;
      scan_wrap <= 1'b0;
      hold_auto <= 1'b0;
      hold_last <= 1'b0;
`ifdef MUX_TDM_PARITY_EN
      data_par  <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      dwell_cnt <= dwell_nxt;
      scan_ptr  <= ptr_nxt;
      data_out  <= data_nxt;
      ch_out    <= ch_nxt;
      out_valid <= valid_nxt;
      scan_wrap <= wrap_nxt;
      hold_auto <= auto_nxt;
      hold_last <= last_nxt;
`ifdef MUX_TDM_PARITY_EN
      data_par  <= par_nxt;
`endif
    end
  end

  // Mode and the is-last flag are latched at SAMPLE so that HOLD-time
  // changes to mode or mask only affect the next sample.
  always_comb begin
    state_nxt = state;
    dwell_nxt = dwell_cnt;
    ptr_nxt   = scan_ptr;
    data_nxt  = data_out;
    ch_nxt    = ch_out;
    valid_nxt = out_valid;
    wrap_nxt  = 1'b0;
    auto_nxt  = hold_auto;
    last_nxt  = hold_last;
`ifdef MUX_TDM_PARITY_EN
    par_nxt   = data_par;
`endif
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = WAIT;
          dwell_nxt = DWELL_LOAD;
        end
      end
      WAIT: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (dwell_cnt == '0) begin
          state_nxt = SAMPLE;
        end else begin
          dwell_nxt = dwell_cnt - 1'b1;
        end
      end
      SAMPLE: begin
        if (mode == MODE_AUTO && !pick_found) begin
          state_nxt = WAIT;
          dwell_nxt = DWELL_LOAD;
        end else begin
          state_nxt = HOLD;
          data_nxt  = sample_word;
          ch_nxt    = sample_ch;
          valid_nxt = 1'b1;
          auto_nxt  = (mode == MODE_AUTO);
          last_nxt  = (mode == MODE_AUTO) && pick_last;
`ifdef MUX_TDM_PARITY_EN
          par_nxt   = ^sample_word;
`endif
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_nxt = 1'b0;
          dwell_nxt = DWELL_LOAD;
          state_nxt = en ? WAIT : IDLE;
          if (hold_auto) begin
            ptr_nxt  = (ch_out == SEL_W'(N_CH - 1)) ? '0 : ch_out + 1'b1;
            wrap_nxt = hold_last;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_tdm_scan.sv
// Scoreboard testbench for mux_tdm_scan: an 8-channel instance plus a 6-channel one for out-of-range select.
module tb_mux_tdm_scan;

  typedef struct {
    logic [7:0] data;
    logic [2:0] ch;
    logic       wrap;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        en = 1'b0, mode = 1'b0, out_ready = 1'b0;
  logic [2:0]  sel_in = '0;
  logic [7:0]  ch_mask = '0;
  logic [63:0] data_in;
  logic [7:0]  data_out;
  logic [2:0]  ch_out;
  logic        out_valid, scan_wrap;

  logic        en1 = 1'b0, mode1 = 1'b0, ready1 = 1'b0;
  logic [2:0]  sel1 = '0;
  logic [5:0]  mask1 = '0;
  logic [47:0] data1;
  logic [7:0]  dout1;
  logic [2:0]  chout1;
  logic        valid1, wrap1;
`ifdef MUX_TDM_PARITY_EN
  logic        data_par, par1;
`endif

  always #5 clk = ~clk;

  mux_tdm_scan #(.N_CH(8), .DATA_W(8), .DWELL(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .sel_in    (sel_in),
    .ch_mask   (ch_mask),
    .data_in   (data_in),
    .data_out  (data_out),
    .ch_out    (ch_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .scan_wrap (scan_wrap)
`ifdef MUX_TDM_PARITY_EN
    ,
    .data_par  (data_par)
`endif
  );

  mux_tdm_scan #(.N_CH(6), .DATA_W(8), .DWELL(2)) dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en1),
    .mode      (mode1),
    .sel_in    (sel1),
    .ch_mask   (mask1),
    .data_in   (data1),
    .data_out  (dout1),
    .ch_out    (chout1),
    .out_valid (valid1),
    .out_ready (ready1),
    .scan_wrap (wrap1)
`ifdef MUX_TDM_PARITY_EN
    ,
    .data_par  (par1)
`endif
  );

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; en1 = 1'b0; out_ready = 1'b0; ready1 = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns the next accepted sample and the scan_wrap value seen just after acceptance.
  task automatic wait_accept(output logic [7:0] d, output logic [2:0] c, output logic w,
                             output int cyc, output bit ok);
    ok = 1'b0; cyc = 0; d = '0; c = '0; w = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        d  = data_out;
        c  = ch_out;
        ok = 1'b1;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (ok) w = scan_wrap;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL reset data_out: got %0h, expected 0", data_out); end
    checks++; if (ch_out !== 3'd0) begin errors++; $display("[TB] FAIL reset ch_out: got %0d, expected 0", ch_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset out_valid: got %b, expected 0", out_valid); end
    checks++; if (scan_wrap !== 1'b0) begin errors++; $display("[TB] FAIL reset scan_wrap: got %b, expected 0", scan_wrap); end
    rst_n = 1'b1;
  endtask

  task automatic test_manual();
    logic [7:0] d; logic [2:0] c; logic w; int cyc; bit ok; exp_t e;
    int n; bit seen;
    do_reset();
    mode = 1'b0; sel_in = 3'd5; out_ready = 1'b1; en = 1'b1;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); n++; #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (!seen || n != 4) begin errors++; $display("[TB] FAIL manual first_latency: got %0d edges (seen=%b), expected 4", n, seen); end
    for (int i = 0; i < 3; i++) sb.push_back('{data: 8'h15, ch: 3'd5, wrap: 1'b0});
    for (int i = 0; i < 3; i++) begin
      wait_accept(d, c, w, cyc, ok);
      e = sb.pop_front();
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL manual timeout: got no sample, expected ch %0d", e.ch); end
      else begin
        checks++; if (d !== e.data) begin errors++; $display("[TB] FAIL manual data: got %0h, expected %0h", d, e.data); end
        checks++; if (c !== e.ch) begin errors++; $display("[TB] FAIL manual ch: got %0d, expected %0d", c, e.ch); end
        if (i > 0) begin
          checks++; if (cyc != 4) begin errors++; $display("[TB] FAIL manual period: got %0d, expected 4", cyc); end
        end else begin
          checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL manual valid_drop: got %b, expected 0", out_valid); end
        end
      end
    end
  endtask

  task automatic run_auto(input string name, input logic [7:0] mask, input int n, input logic [2:0] seq[]);
    logic [7:0] d; logic [2:0] c; logic w; int cyc; bit ok; exp_t e;
    do_reset();
    mode = 1'b1; ch_mask = mask; out_ready = 1'b1; en = 1'b1;
    for (int i = 0; i < n; i++) sb.push_back('{data: 8'h10 + 8'(seq[i]), ch: seq[i], wrap: (seq[i] == 3'd7)});
    for (int i = 0; i < n; i++) begin
      wait_accept(d, c, w, cyc, ok);
      e = sb.pop_front();
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL %s timeout: got no sample, expected ch %0d", name, e.ch); end
      else begin
        checks++; if (c !== e.ch) begin errors++; $display("[TB] FAIL %s ch[%0d]: got %0d, expected %0d", name, i, c, e.ch); end
        checks++; if (d !== e.data) begin errors++; $display("[TB] FAIL %s data[%0d]: got %0h, expected %0h", name, i, d, e.data); end
        checks++; if (w !== e.wrap) begin errors++; $display("[TB] FAIL %s wrap[%0d]: got %b, expected %b", name, i, w, e.wrap); end
      end
    end
  endtask

  task automatic test_auto_full();
    logic [2:0] seq[] = new[9];
    for (int i = 0; i < 9; i++) seq[i] = 3'(i % 8);
    run_auto("auto_full", 8'hFF, 9, seq);
  endtask

  task automatic test_auto_sparse();
    logic [2:0] seq[] = new[5];
    seq[0] = 3'd2; seq[1] = 3'd5; seq[2] = 3'd7; seq[3] = 3'd2; seq[4] = 3'd5;
    run_auto("auto_sparse", 8'b1010_0100, 5, seq);
  endtask

  task automatic test_backpressure();
    logic [7:0] d; logic [2:0] c; logic w; int cyc; bit ok; exp_t e;
    bit seen; bit stable;
    do_reset();
    mode = 1'b1; ch_mask = 8'hFF; out_ready = 1'b1; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_accept(d, c, w, cyc, ok);
      checks++; if (!ok || c !== 3'(i)) begin errors++; $display("[TB] FAIL bp_prefill ch: got %0d, expected %0d", c, i); end
    end
    out_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL bp_hold timeout: got no out_valid, expected 1"); end
    checks++; if (ch_out !== 3'd3 || data_out !== 8'h13) begin errors++; $display("[TB] FAIL bp_hold sample: got ch %0d data %0h, expected ch 3 data 13", ch_out, data_out); end
`ifdef MUX_TDM_PARITY_EN
    checks++; if (data_par !== 1'b1) begin errors++; $display("[TB] FAIL parity: got %b, expected 1", data_par); end
`endif
    ch_mask = 8'h01;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (data_out !== 8'h13 || ch_out !== 3'd3 || out_valid !== 1'b1) stable = 1'b0;
    end
    checks++; if (!stable) begin errors++; $display("[TB] FAIL bp_stable: got ch %0d data %0h valid %b, expected ch 3 data 13 valid 1", ch_out, data_out, out_valid); end
    out_ready = 1'b1;
    sb.push_back('{data: 8'h13, ch: 3'd3, wrap: 1'b0});
    sb.push_back('{data: 8'h10, ch: 3'd0, wrap: 1'b1});
    for (int i = 0; i < 2; i++) begin
      wait_accept(d, c, w, cyc, ok);
      e = sb.pop_front();
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL bp timeout: got no sample, expected ch %0d", e.ch); end
      else begin
        checks++; if (c !== e.ch || d !== e.data) begin errors++; $display("[TB] FAIL bp sample[%0d]: got ch %0d data %0h, expected ch %0d data %0h", i, c, d, e.ch, e.data); end
        checks++; if (w !== e.wrap) begin errors++; $display("[TB] FAIL bp wrap[%0d]: got %b, expected %b", i, w, e.wrap); end
      end
    end
  endtask

  task automatic test_mask_zero();
    logic [7:0] d; logic [2:0] c; logic w; int cyc; bit ok; exp_t e;
    bit seen;
    do_reset();
    mode = 1'b1; ch_mask = 8'h00; out_ready = 1'b1; en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("[TB] FAIL mask_zero valid: got 1, expected 0"); end
    ch_mask = 8'h08;
    sb.push_back('{data: 8'h13, ch: 3'd3, wrap: 1'b1});
    wait_accept(d, c, w, cyc, ok);
    e = sb.pop_front();
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL mask_zero timeout: got no sample, expected ch 3"); end
    else begin
      checks++; if (c !== e.ch || d !== e.data) begin errors++; $display("[TB] FAIL mask_zero sample: got ch %0d data %0h, expected ch %0d data %0h", c, d, e.ch, e.data); end
      checks++; if (w !== e.wrap) begin errors++; $display("[TB] FAIL mask_zero wrap: got %b, expected %b", w, e.wrap); end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [7:0] d; logic [2:0] c; logic w; int cyc; bit ok; exp_t e;
    bit seen;
    do_reset();
    mode = 1'b1; ch_mask = 8'hFF; out_ready = 1'b1; en = 1'b1;
    for (int i = 0; i < 2; i++) wait_accept(d, c, w, cyc, ok);
    out_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (!seen || data_out !== 8'h12) begin errors++; $display("[TB] FAIL midhold setup: got valid %b data %0h, expected valid 1 data 12", seen, data_out); end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (data_out !== 8'h00 || ch_out !== 3'd0 || out_valid !== 1'b0 || scan_wrap !== 1'b0) begin
      errors++; $display("[TB] FAIL midhold async_clear: got data %0h ch %0d valid %b wrap %b, expected all 0", data_out, ch_out, out_valid, scan_wrap);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    sb.push_back('{data: 8'h10, ch: 3'd0, wrap: 1'b0});
    wait_accept(d, c, w, cyc, ok);
    e = sb.pop_front();
    checks++; if (!ok || c !== e.ch || d !== e.data) begin errors++; $display("[TB] FAIL midhold restart: got ch %0d data %0h ok %b, expected ch %0d data %0h", c, d, ok, e.ch, e.data); end
  endtask

  task automatic test_manual_oob();
    bit seen;
    do_reset();
    mode1 = 1'b0; sel1 = 3'd7; ready1 = 1'b0; en1 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (valid1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL oob timeout: got no out_valid, expected 1"); end
    checks++; if (dout1 !== 8'h00 || chout1 !== 3'd7) begin errors++; $display("[TB] FAIL oob sample: got data %0h ch %0d, expected data 0 ch 7", dout1, chout1); end
    sel1 = 3'd4; ready1 = 1'b1;
    @(posedge clk); #1;
    ready1 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (valid1) seen = 1'b1;
    end
    checks++; if (!seen || dout1 !== 8'h14 || chout1 !== 3'd4) begin errors++; $display("[TB] FAIL oob in_range: got data %0h ch %0d, expected data 14 ch 4", dout1, chout1); end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) data_in[k*8 +: 8] = 8'h10 + 8'(k);
    for (int k = 0; k < 6; k++) data1[k*8 +: 8] = 8'h10 + 8'(k);
    test_reset();
    test_manual();
    test_auto_full();
    test_auto_sparse();
    test_backpressure();
    test_mask_zero();
    test_reset_mid_hold();
    test_manual_oob();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
